// File: rtl/blake2_stream_ctrl.sv
// blake2_stream_ctrl: packs a valid/ready word stream into ping-ponged blocks
// and sequences init/next/final_block commands. Optional abort: BLAKE2_CTRL_ABORT_EN.
module blake2_stream_ctrl #(
    parameter int  BUS_WIDTH   = 64,
    parameter int  BLOCK_WIDTH = 1024,
    parameter int  NUM_BUFS    = 2,
    localparam int PACKETS     = BLOCK_WIDTH / BUS_WIDTH,
    localparam int WBYTES      = BUS_WIDTH / 8,
    localparam int NB_W        = $clog2(WBYTES)
) (
    input  logic                   clk,
    input  logic                   reset_n,
    input  logic [BUS_WIDTH-1:0]   din,
    input  logic                   in_valid,
    output logic                   in_ready,
    input  logic                   in_last,
    input  logic [NB_W-1:0]        in_nbytes,
    output logic                   busy,
    output logic                   init,
    output logic                   next,
    output logic                   final_block,
    output logic [BLOCK_WIDTH-1:0] block,
    output logic [63:0]            data_length,
`ifdef BLAKE2_CTRL_ABORT_EN
    input  logic                   abort,
`endif
    input  logic                   hash_ready,
    input  logic                   digest_valid
);

    localparam int PTR_W = (PACKETS > 1) ? $clog2(PACKETS) : 1;
    localparam int BI_W  = (NUM_BUFS > 1) ? $clog2(NUM_BUFS) : 1;
    localparam int CNT_W = $clog2(BLOCK_WIDTH / 8 + 1);

    typedef enum logic [1:0] {
        MSG_IDLE,
        MSG_OPEN,
        MSG_CLOSED
    } msg_t;

    typedef enum logic {
        ISSUE_IDLE,
        ISSUE_ACK
    } iss_t;

    logic [BLOCK_WIDTH-1:0] r_buf [NUM_BUFS];
    logic [CNT_W-1:0]       r_tag_cnt [NUM_BUFS];
    logic [NUM_BUFS-1:0]    r_full;
    logic [NUM_BUFS-1:0]    r_tag_first;
    logic [NUM_BUFS-1:0]    r_tag_final;
    logic [PTR_W-1:0]       r_ptr;
    logic [BI_W-1:0]        r_fill;
    logic [BI_W-1:0]        r_head;
    logic                   r_first_pend;
    logic                   r_final_issued;
    logic                   r_dv_d;
    logic                   r_init;
    logic                   r_next;
    logic                   r_final;
    logic [BLOCK_WIDTH-1:0] r_block;
    logic [63:0]            r_len;
    msg_t                   r_msg;
    msg_t                   w_msg_nxt;
    iss_t                   r_iss;
    iss_t                   w_iss_nxt;

    logic                   w_abort;
    logic                   w_accept;
    logic                   w_close;
    logic                   w_dv_rise;
    logic                   w_done;
    logic                   w_issue;
    logic [BUS_WIDTH-1:0]   w_word;
    logic [CNT_W-1:0]       w_wbytes;
    logic [CNT_W-1:0]       w_cnt;

`ifdef BLAKE2_CTRL_ABORT_EN
    assign w_abort = abort;
`else
    assign w_abort = 1'b0;
`endif

    function automatic logic [BI_W-1:0] f_inc(input logic [BI_W-1:0] i);
        return (i == BI_W'(NUM_BUFS - 1)) ? '0 : i + BI_W'(1);
    endfunction

    assign in_ready  = !r_full[r_fill] && (r_msg != MSG_CLOSED);
    assign busy      = (r_msg != MSG_IDLE) || (|r_full);
    assign w_accept  = in_valid && in_ready;
    assign w_close   = w_accept && (in_last || r_ptr == PTR_W'(PACKETS - 1));
    assign w_dv_rise = digest_valid && !r_dv_d;
    assign w_done    = w_dv_rise && (r_msg == MSG_CLOSED) && r_final_issued;
    assign w_issue   = (r_iss == ISSUE_IDLE) && r_full[r_head] &&
                       hash_ready && !w_abort;
    assign w_cnt     = CNT_W'(r_ptr) * CNT_W'(WBYTES) + w_wbytes;

    assign init        = r_init;
    assign next        = r_next;
    assign final_block = r_final;
    assign block       = r_block;
    assign data_length = r_len;

    // Partial last word: keep bytes below in_nbytes, zero the rest.
    always_comb begin
        w_word   = din;
        w_wbytes = CNT_W'(WBYTES);
        if (in_last && in_nbytes != '0) begin
            w_wbytes = CNT_W'(in_nbytes);
            for (int b = 0; b < WBYTES; b++) begin
                if (b >= int'(in_nbytes)) begin
                    w_word[8*b +: 8] = 8'h00;
                end
            end
        end
    end

    always_comb begin
        w_msg_nxt = r_msg;
        unique case (r_msg)
            MSG_IDLE: begin
                if (w_accept) begin
                    w_msg_nxt = in_last ? MSG_CLOSED : MSG_OPEN;
                end
            end
            MSG_OPEN: begin
                if (w_accept && in_last) begin
                    w_msg_nxt = MSG_CLOSED;
                end
            end
            MSG_CLOSED: begin
                if (w_done) begin
                    w_msg_nxt = MSG_IDLE;
                end
            end
            default: w_msg_nxt = MSG_IDLE;
        endcase
        if (w_abort) begin
            w_msg_nxt = MSG_IDLE;
        end
    end

    // ISSUE_ACK is the disarmed state: wait for the engine to drop hash_ready.
    always_comb begin
        w_iss_nxt = r_iss;
        unique case (r_iss)
            ISSUE_IDLE: begin
                if (w_issue) begin
                    w_iss_nxt = ISSUE_ACK;
                end
            end
            ISSUE_ACK: begin
                if (!hash_ready) begin
                    w_iss_nxt = ISSUE_IDLE;
                end
            end
            default: w_iss_nxt = ISSUE_IDLE;
        endcase
        if (w_abort) begin
            w_iss_nxt = ISSUE_IDLE;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_msg <= MSG_IDLE;
            r_iss <= ISSUE_IDLE;
        end else begin
            r_msg <= w_msg_nxt;
            r_iss <= w_iss_nxt;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int i = 0; i < NUM_BUFS; i++) begin
                r_buf[i]     <= '0;
                r_tag_cnt[i] <= '0;
            end
            r_full         <= '0;
            r_tag_first    <= '0;
            r_tag_final    <= '0;
            r_ptr          <= '0;
            r_fill         <= '0;
            r_head         <= '0;
            r_first_pend   <= 1'b1;
            r_final_issued <= 1'b0;
            r_dv_d         <= 1'b0;
            r_init         <= 1'b0;
            r_next         <= 1'b0;
            r_final        <= 1'b0;
            r_block        <= '0;
            r_len          <= '0;
        end else begin
            r_dv_d  <= digest_valid;
            r_init  <= 1'b0;
            r_next  <= 1'b0;
            r_final <= 1'b0;
            if (w_abort) begin
                for (int i = 0; i < NUM_BUFS; i++) begin
                    r_buf[i]     <= '0;
                    r_tag_cnt[i] <= '0;
                end
                r_full         <= '0;
                r_tag_first    <= '0;
                r_tag_final    <= '0;
                r_ptr          <= '0;
                r_fill         <= '0;
                r_head         <= '0;
                r_first_pend   <= 1'b1;
                r_final_issued <= 1'b0;
                r_len          <= '0;
            end else begin
                if (w_issue) begin
                    r_block        <= r_buf[r_head];
                    r_len          <= r_len + 64'(r_tag_cnt[r_head]);
                    r_init         <= r_tag_first[r_head];
                    r_next         <= !r_tag_first[r_head];
                    r_final        <= r_tag_final[r_head];
                    r_buf[r_head]  <= '0;
                    r_full[r_head] <= 1'b0;
                    r_head         <= f_inc(r_head);
                    if (r_tag_final[r_head]) begin
                        r_final_issued <= 1'b1;
                    end
                end
                if (w_accept) begin
                    r_buf[r_fill][r_ptr*BUS_WIDTH +: BUS_WIDTH] <= w_word;
                    if (w_close) begin
                        r_full[r_fill]      <= 1'b1;
                        r_tag_first[r_fill] <= r_first_pend;
                        r_tag_final[r_fill] <= in_last;
                        r_tag_cnt[r_fill]   <= w_cnt;
                        r_fill              <= f_inc(r_fill);
                        r_ptr               <= '0;
                        r_first_pend        <= in_last;
                    end else begin
                        r_ptr <= r_ptr + PTR_W'(1);
                    end
                end
                if (w_done) begin
                    r_len          <= '0;
                    r_final_issued <= 1'b0;
                end
            end
        end
    end

endmodule
